// File: rtl/ddr3_lane_delay_step_ctrl.sv
// rtl/ddr3_lane_delay_step_ctrl.sv - DQS delay-line load/move strobe sequencer with tap tracking
module ddr3_lane_delay_step_ctrl #(
  parameter int TAP_W         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int RX_INIT_TAP   = 1,
  parameter int TX_INIT_TAP   = 1
) (
  input  logic             i_fab_clk,
  input  logic             i_reset_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic             i_cmd_sel,
  input  logic [TAP_W-1:0] i_cmd_count,
  output logic             o_done,
  output logic             o_err,
  output logic [TAP_W-1:0] o_rx_tap,
  output logic [TAP_W-1:0] o_tx_tap,
  output logic             o_delay_line_sel,
  output logic             o_delay_line_direction,
  output logic             o_delay_line_load,
  output logic             o_delay_line_move,
  input  logic             i_rx_delay_line_out_of_range,
  input  logic             i_tx_delay_line_out_of_range
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_SETTLE, S_CHECK} state_t;

  localparam logic [1:0]       OP_LOAD     = 2'b00;
  localparam logic [1:0]       OP_INC      = 2'b01;
  localparam logic [1:0]       OP_DEC      = 2'b10;
  localparam logic [1:0]       OP_RSV      = 2'b11;
  localparam logic [TAP_W-1:0] TAP_MAX     = '1;
  localparam logic [TAP_W-1:0] RX_INIT     = TAP_W'(RX_INIT_TAP);
  localparam logic [TAP_W-1:0] TX_INIT     = TAP_W'(TX_INIT_TAP);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           r_state, w_state_n;
  logic [1:0]       r_op, w_op_n;
  logic [TAP_W-1:0] r_rem, w_rem_n;
  logic [TAP_W-1:0] r_rx_tap, w_rx_tap_n;
  logic [TAP_W-1:0] r_tx_tap, w_tx_tap_n;
  logic [3:0]       r_cnt, w_cnt_n;
  logic             r_ready, w_ready_n;
  logic             r_done, w_done_n;
  logic             r_err, w_err_n;
  logic             r_sel, w_sel_n;
  logic             r_dir, w_dir_n;
  logic             r_load, w_load_n;
  logic             r_move, w_move_n;
  logic [TAP_W-1:0] w_in_tap;
  logic [TAP_W-1:0] w_cur_tap;
  logic             w_flag;

  function automatic logic step_blocked(input logic [1:0] op, input logic [TAP_W-1:0] tap);
    return (op == OP_INC && tap == TAP_MAX) || (op == OP_DEC && tap == '0);
  endfunction

  assign w_in_tap  = i_cmd_sel ? r_tx_tap : r_rx_tap;
  assign w_cur_tap = r_sel ? r_tx_tap : r_rx_tap;
  assign w_flag    = r_sel ? i_tx_delay_line_out_of_range : i_rx_delay_line_out_of_range;

  // Done/err are decided one edge early so they are visible in the SETUP/CHECK cycle itself.
  always_comb begin
    w_state_n  = r_state;
    w_op_n     = r_op;
    w_rem_n    = r_rem;
    w_rx_tap_n = r_rx_tap;
    w_tx_tap_n = r_tx_tap;
    w_cnt_n    = r_cnt;
    w_ready_n  = r_ready;
    w_done_n   = 1'b0;
    w_err_n    = 1'b0;
    w_sel_n    = r_sel;
    w_dir_n    = r_dir;
    w_load_n   = 1'b0;
    w_move_n   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_cmd_valid && r_ready) begin
          w_state_n = S_SETUP;
          w_ready_n = 1'b0;
          w_op_n    = i_cmd_op;
          w_sel_n   = i_cmd_sel;
          w_dir_n   = (i_cmd_op == OP_INC);
          w_rem_n   = (i_cmd_op == OP_LOAD) ? TAP_W'(1) : i_cmd_count;
          if (i_cmd_op == OP_RSV)
            w_err_n = 1'b1;
          else if (i_cmd_op != OP_LOAD && i_cmd_count == '0)
            w_done_n = 1'b1;
          else if (step_blocked(i_cmd_op, w_in_tap))
            w_err_n = 1'b1;
        end
      end
      S_SETUP, S_CHECK: begin
        if (r_done || r_err) begin
          w_state_n = S_IDLE;
          w_ready_n = 1'b1;
        end else begin
          w_state_n = S_PULSE;
          w_load_n  = (r_op == OP_LOAD);
          w_move_n  = (r_op != OP_LOAD);
        end
      end
      S_PULSE: begin
        w_state_n = S_SETTLE;
        w_cnt_n   = '0;
        w_rem_n   = r_rem - TAP_W'(1);
        unique case (r_op)
          OP_INC:  if (r_sel) w_tx_tap_n = r_tx_tap + TAP_W'(1); else w_rx_tap_n = r_rx_tap + TAP_W'(1);
          OP_DEC:  if (r_sel) w_tx_tap_n = r_tx_tap - TAP_W'(1); else w_rx_tap_n = r_rx_tap - TAP_W'(1);
          default: if (r_sel) w_tx_tap_n = TX_INIT;              else w_rx_tap_n = RX_INIT;
        endcase
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_n = S_CHECK;
          if (w_flag)
            w_err_n = 1'b1;
          else if (r_rem == '0)
            w_done_n = 1'b1;
          else if (step_blocked(r_op, w_cur_tap))
            w_err_n = 1'b1;
        end else begin
          w_cnt_n = r_cnt + 4'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_fab_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_LOAD;
      r_rem    <= '0;
      r_rx_tap <= RX_INIT;
      r_tx_tap <= TX_INIT;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_sel    <= 1'b0;
      r_dir    <= 1'b0;
      r_load   <= 1'b0;
      r_move   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_op     <= w_op_n;
      r_rem    <= w_rem_n;
      r_rx_tap <= w_rx_tap_n;
      r_tx_tap <= w_tx_tap_n;
      r_cnt    <= w_cnt_n;
      r_ready  <= w_ready_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
      r_sel    <= w_sel_n;
      r_dir    <= w_dir_n;
      r_load   <= w_load_n;
      r_move   <= w_move_n;
    end
  end

  assign o_cmd_ready            = r_ready;
  assign o_done                 = r_done;
  assign o_err                  = r_err;
  assign o_rx_tap               = r_rx_tap;
  assign o_tx_tap               = r_tx_tap;
  assign o_delay_line_sel       = r_sel;
  assign o_delay_line_direction = r_dir;
  assign o_delay_line_load      = r_load;
  assign o_delay_line_move      = r_move;

endmodule

// File: tb/tb_ddr3_lane_delay_step_ctrl.sv
// tb/tb_ddr3_lane_delay_step_ctrl.sv - directed and random command checks against a step-count model
module tb_ddr3_lane_delay_step_ctrl;

  localparam int SETTLE = 4;
  localparam int PER    = SETTLE + 2;
  localparam int TMAX   = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_sel;
  logic [7:0] cmd_count;
  logic       done, err;
  logic [7:0] rx_tap, tx_tap;
  logic       dl_sel, dl_dir, dl_load, dl_move;
  logic       rx_oor, tx_oor;

  int n_cmp = 0;
  int n_err = 0;
  int m_rx  = 1;
  int m_tx  = 1;

  ddr3_lane_delay_step_ctrl #(
    .TAP_W(8), .SETTLE_CYCLES(SETTLE), .RX_INIT_TAP(1), .TX_INIT_TAP(1)
  ) dut (
    .i_fab_clk(clk),
    .i_reset_n(rst_n),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op),
    .i_cmd_sel(cmd_sel),
    .i_cmd_count(cmd_count),
    .o_done(done),
    .o_err(err),
    .o_rx_tap(rx_tap),
    .o_tx_tap(tx_tap),
    .o_delay_line_sel(dl_sel),
    .o_delay_line_direction(dl_dir),
    .o_delay_line_load(dl_load),
    .o_delay_line_move(dl_move),
    .i_rx_delay_line_out_of_range(rx_oor),
    .i_tx_delay_line_out_of_range(tx_oor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=T+%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 0, cmd_ready, 1);
    chk({tag, "_done"},  0, done, 0);
    chk({tag, "_err"},   0, err, 0);
    chk({tag, "_strb"},  0, {dl_sel, dl_dir, dl_load, dl_move}, 0);
    chk({tag, "_rx"},    0, rx_tap, 1);
    chk({tag, "_tx"},    0, tx_tap, 1);
  endtask

  // Issues one command at a negedge and follows it cycle by cycle until ready returns.
  // fj: the selected out-of-range flag rises right after the fj-th step (0 = never).
  task automatic run(input logic [1:0] op, input logic sel, input int cnt, input int fj,
                     input bit chain, input logic [1:0] nop, input logic nsel, input int ncnt);
    int start, p, e, lim, jj, pb, exp_sel_tap, exp_oth;
    bit er, pulse;
    chk("ready_pre", 0, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_count = 8'(cnt);
    start     = sel ? m_tx : m_rx;
    exp_oth   = sel ? m_rx : m_tx;
    if (op == 2'b11) begin
      p = 0; e = 1; er = 1'b1;
    end else if (op == 2'b00) begin
      p = 1; e = 1 + PER; er = (fj == 1);
    end else if (cnt == 0) begin
      p = 0; e = 1; er = 1'b0;
    end else begin
      lim = (op == 2'b01) ? TMAX - start : start;
      jj  = (fj == 0) ? 1 << 20 : fj;
      p   = cnt;
      if (lim < p) p = lim;
      if (jj < p)  p = jj;
      e   = (p == 0) ? 1 : 1 + p * PER;
      er  = (p < cnt) || (fj != 0 && fj == p);
    end
    if (sel) rx_oor = 1'($urandom % 2); else tx_oor = 1'($urandom % 2);
    @(posedge clk);
    #1;
    if (chain) begin
      cmd_op = nop; cmd_sel = nsel; cmd_count = 8'(ncnt);
    end else begin
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom); cmd_sel = 1'($urandom); cmd_count = 8'($urandom);
    end
    for (int k = 1; k <= e + 1; k++) begin
      @(negedge clk);
      pulse = (k >= 2) && ((k - 2) % PER == 0) && ((k - 2) / PER < p);
      pb = (k <= 2) ? 0 : ((k - 3) / PER + 1);
      if (pb > p) pb = p;
      if (op == 2'b00)      exp_sel_tap = (pb > 0) ? 1 : start;
      else if (op == 2'b01) exp_sel_tap = start + pb;
      else                  exp_sel_tap = start - pb;
      chk("move",  k, dl_move, pulse && op != 2'b00);
      chk("load",  k, dl_load, pulse && op == 2'b00);
      chk("done",  k, done,    (k == e) && !er);
      chk("err",   k, err,     (k == e) && er);
      chk("ready", k, cmd_ready, k == e + 1);
      chk("rx_tap", k, rx_tap, sel ? exp_oth : exp_sel_tap);
      chk("tx_tap", k, tx_tap, sel ? exp_sel_tap : exp_oth);
      if (k <= e) begin
        chk("sel", k, dl_sel, sel);
        chk("dir", k, dl_dir, op == 2'b01);
      end
      if (fj != 0 && fj <= p && k == 2 + PER * (fj - 1)) begin
        if (sel) tx_oor = 1'b1; else rx_oor = 1'b1;
      end
    end
    rx_oor = 1'b0;
    tx_oor = 1'b0;
    if (op == 2'b00)      start = 1;
    else if (op == 2'b01) start = start + p;
    else if (op == 2'b10) start = start - p;
    if (sel) m_tx = start; else m_rx = start;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_sel = 1'b0; cmd_count = 8'd0;
    rx_oor = 1'b0; tx_oor = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("reset");

    run(2'b01, 1'b0, 3, 0, 1'b0, 2'b00, 1'b0, 0);   // RX 1 -> 4
    run(2'b01, 1'b1, 8, 0, 1'b0, 2'b00, 1'b0, 0);   // TX 1 -> 9
    run(2'b00, 1'b1, 0, 0, 1'b0, 2'b00, 1'b0, 0);   // TX load back to 1
    run(2'b00, 1'b0, 0, 0, 1'b0, 2'b00, 1'b0, 0);
    run(2'b01, 1'b0, 1, 0, 1'b0, 2'b00, 1'b0, 0);   // RX = 2
    run(2'b10, 1'b0, 5, 0, 1'b0, 2'b00, 1'b0, 0);   // blocked at 0 after two steps
    run(2'b10, 1'b0, 3, 0, 1'b0, 2'b00, 1'b0, 0);   // blocked before the first step
    run(2'b01, 1'b1, 4, 2, 1'b0, 2'b00, 1'b0, 0);   // TX out-of-range after step 2
    run(2'b10, 1'b1, 0, 0, 1'b0, 2'b00, 1'b0, 0);   // zero-count move
    run(2'b11, 1'b1, 7, 0, 1'b0, 2'b00, 1'b0, 0);   // reserved op
    run(2'b00, 1'b0, 0, 1, 1'b0, 2'b00, 1'b0, 0);   // load with out-of-range
    run(2'b00, 1'b0, 0, 0, 1'b1, 2'b01, 1'b0, 1);   // back-to-back, valid held
    run(2'b01, 1'b0, 1, 0, 1'b0, 2'b00, 1'b0, 0);

    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_sel = 1'b0; cmd_count = 8'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    m_rx = 1; m_tx = 1;
    repeat (3) begin
      @(negedge clk);
      chk_reset_state("postrst");
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      int c, f;
      op = 2'($urandom);
      c  = int'($urandom_range(0, 10));
      f  = ($urandom % 3 == 0) ? int'($urandom_range(1, 11)) : 0;
      run(op, 1'($urandom), c, f, 1'b0, 2'b00, 1'b0, 0);
    end

    run(2'b00, 1'b0, 0, 0, 1'b0, 2'b00, 1'b0, 0);
    run(2'b01, 1'b0, 255, 0, 1'b0, 2'b00, 1'b0, 0); // saturates at 255
    run(2'b01, 1'b0, 1, 0, 1'b0, 2'b00, 1'b0, 0);
    run(2'b10, 1'b0, 2, 0, 1'b0, 2'b00, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
